sipo_rx: RTL and testbench



---
 rtl/sipo_rx.sv | 123 ++++++++++++
 tb/tb_sipo_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in, parallel-out receiver for the serial shift link.
// Collects WIDTH qualified serial bits into a word and presents it on a
// parallel output with a valid/ready handshake. One completed word is held
// while the next word shifts in; a word that cannot be delivered is dropped
// and recorded in a sticky overrun flag.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   sin        serial data bit
//   sin_en     qualifies sin; a bit is captured only when high
//   flush      discards the partial word in progress
//   dout       completed parallel word
//   dout_valid dout holds an unconsumed word
//   dout_ready consumer accepts dout when dout_valid & dout_ready
//   bit_cnt    bits of the current partial word received so far
//   overrun    sticky: a completed word was dropped
//   ovr_clr    clears overrun
module sipo_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       sin_en,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun,
  input  logic                       ovr_clr
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic             capture;
  logic             complete;
  logic             accept;

  // Shift register with the current sin already inserted; on the completion
  // edge this is the full word.
  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], sin};
    end else begin
      shifted = {sin, shift_q[WIDTH-1:1]};
    end
  end

  assign capture  = sin_en && !flush;
  assign complete = capture && (cnt_q == CNT_LAST);
  assign accept   = !valid_q || dout_ready;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (flush) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sin_en) begin
      if (complete) begin
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = shifted;
        cnt_d   = cnt_q + CW'(1);
      end
    end

    // A completion into a busy output drops the word; a completion into a
    // free (or simultaneously consumed) output replaces it with no bubble.
    if (complete && accept) begin
      dout_d  = shifted;
      valid_d = 1'b1;
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end

    // Set beats clear when both happen on the same edge.
    if (complete && !accept) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: an MSB-first and an LSB-first instance share one
// directed stimulus stream. A queue-based model of received bits supplies
// expected outputs checked every cycle, and literal expectations pin the
// model at the interesting points.
module tb_sipo_rx;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sin = 1'b0;
  logic sin_en = 1'b0;
  logic flush = 1'b0;
  logic dout_ready = 1'b0;
  logic ovr_clr = 1'b0;

  logic [W-1:0] dout_m, dout_l;
  logic         valid_m, valid_l;
  logic [2:0]   cnt_m, cnt_l;
  logic         ovr_m, ovr_l;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_en(sin_en), .flush(flush),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .bit_cnt(cnt_m), .overrun(ovr_m), .ovr_clr(ovr_clr)
  );

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_en(sin_en), .flush(flush),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .bit_cnt(cnt_l), .overrun(ovr_l), .ovr_clr(ovr_clr)
  );

  // Model: received bits of the partial word kept in arrival order.
  bit     bq[$];
  int     md_msb = 0;
  int     md_lsb = 0;
  int     mvalid = 0;
  int     movr = 0;

  always @(posedge clk) begin
    int wm, wl;
    bit done, drop;
    done = 1'b0;
    drop = 1'b0;
    wm = 0;
    wl = 0;
    if (reset) begin
      bq.delete();
      md_msb = 0; md_lsb = 0; mvalid = 0; movr = 0;
    end else begin
      if (flush) begin
        bq.delete();
      end else if (sin_en) begin
        bq.push_back(sin);
        if (bq.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm += int'(bq[i]) << (W - 1 - i);
            wl += int'(bq[i]) << i;
          end
          bq.delete();
        end
      end
      if (done) begin
        if (mvalid == 0 || dout_ready) begin
          md_msb = wm; md_lsb = wl; mvalid = 1;
        end else begin
          drop = 1'b1;
        end
      end else if (mvalid == 1 && dout_ready) begin
        mvalid = 0;
      end
      if (drop) movr = 1;
      else if (ovr_clr) movr = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("msb.dout", 32'(dout_m), 32'(md_msb));
      chk("lsb.dout", 32'(dout_l), 32'(md_lsb));
      chk("msb.valid", 32'(valid_m), 32'(mvalid));
      chk("lsb.valid", 32'(valid_l), 32'(mvalid));
      chk("msb.cnt", 32'(cnt_m), 32'(bq.size()));
      chk("lsb.cnt", 32'(cnt_l), 32'(bq.size()));
      chk("msb.ovr", 32'(ovr_m), 32'(movr));
      chk("lsb.ovr", 32'(ovr_l), 32'(movr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    sin_en = 1'b1;
    cyc();
    sin_en = 1'b0;
    sin = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    logic [3:0] pat;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    chk_on = 1'b1;
    chk("reset.dout", 32'(dout_m), 32'h0);
    chk("reset.valid", 32'(valid_m), 32'h0);
    chk("reset.cnt", 32'(cnt_m), 32'h0);
    chk("reset.ovr", 32'(ovr_m), 32'h0);

    // Consecutive bits 1,0,1,1 with ready high.
    dout_ready = 1'b1;
    send_bit(1'b1); chk("seq.cnt1", 32'(cnt_m), 32'd1);
    send_bit(1'b0); chk("seq.cnt2", 32'(cnt_m), 32'd2);
    send_bit(1'b1); chk("seq.cnt3", 32'(cnt_m), 32'd3);
    chk("seq.valid_before", 32'(valid_m), 32'd0);
    send_bit(1'b1); chk("seq.cnt0", 32'(cnt_m), 32'd0);
    chk("seq.dout_msb", 32'(dout_m), 32'hB);
    chk("seq.dout_lsb", 32'(dout_l), 32'hD);
    chk("seq.valid", 32'(valid_m), 32'd1);
    cyc();
    chk("seq.valid_one_cycle", 32'(valid_m), 32'd0);

    // Same bits with two idle cycles between each.
    pat = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      send_bit(pat[i]);
      cyc(); cyc();
      if (i > 0) chk("gap.cnt_hold", 32'(cnt_m), 32'(4 - i));
    end
    chk("gap.dout_msb", 32'(dout_m), 32'hB);
    chk("gap.dout_lsb", 32'(dout_l), 32'hD);

    // Overrun with ready low.
    dout_ready = 1'b0;
    send_word(4'b1010);
    chk("ovr.first_valid", 32'(valid_m), 32'd1);
    send_word(4'b0110);
    chk("ovr.dout_msb", 32'(dout_m), 32'hA);
    chk("ovr.dout_lsb", 32'(dout_l), 32'h5);
    chk("ovr.set", 32'(ovr_m), 32'd1);
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    chk("ovr.cleared", 32'(ovr_m), 32'd0);
    // Drop and clear on the same edge: set wins.
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    ovr_clr = 1'b1;
    send_bit(1'b1);
    ovr_clr = 1'b0;
    chk("ovr.set_wins", 32'(ovr_m), 32'd1);
    chk("ovr.dout_kept", 32'(dout_m), 32'hA);
    ovr_clr = 1'b1;
    dout_ready = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    chk("ovr.consumed", 32'(valid_m), 32'd0);
    chk("ovr.dout_hold", 32'(dout_m), 32'hA);

    // Back-to-back: ready only on the second completion edge.
    send_word(4'hA);
    dout_ready = 1'b0;
    chk("b2b.first", 32'(dout_m), 32'hA);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("b2b.valid_hold", 32'(valid_m), 32'd1);
    dout_ready = 1'b1;
    send_bit(1'b1);
    chk("b2b.second_msb", 32'(dout_m), 32'h5);
    chk("b2b.second_lsb", 32'(dout_l), 32'hA);
    chk("b2b.valid", 32'(valid_m), 32'd1);
    chk("b2b.ovr", 32'(ovr_m), 32'd0);
    cyc();

    // Flush mid-word, then a clean word, then flush on the completion edge.
    send_bit(1'b1); send_bit(1'b1);
    flush = 1'b1;
    send_bit(1'b1);
    flush = 1'b0;
    chk("flush.cnt", 32'(cnt_m), 32'd0);
    send_word(4'b1100);
    chk("flush.dout_msb", 32'(dout_m), 32'hC);
    chk("flush.dout_lsb", 32'(dout_l), 32'h3);
    cyc();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    flush = 1'b1;
    send_bit(1'b1);
    flush = 1'b0;
    chk("flush.no_valid", 32'(valid_m), 32'd0);
    chk("flush.cnt_last", 32'(cnt_m), 32'd0);
    chk("flush.dout_kept", 32'(dout_m), 32'hC);

    // Reset mid-word with a pending word and overrun set.
    dout_ready = 1'b0;
    send_word(4'b0110);
    send_word(4'b1111);
    send_bit(1'b1); send_bit(1'b0);
    chk("rst.pre_ovr", 32'(ovr_m), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst.dout", 32'(dout_m), 32'h0);
    chk("rst.valid", 32'(valid_m), 32'd0);
    chk("rst.cnt", 32'(cnt_m), 32'd0);
    chk("rst.ovr", 32'(ovr_m), 32'd0);
    dout_ready = 1'b1;
    send_word(4'b1001);
    chk("rst.after_msb", 32'(dout_m), 32'h9);
    chk("rst.after_lsb", 32'(dout_l), 32'h9);
    cyc(); cyc();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
